// File: rtl/ccheck_pkg.sv
// Shared types and default sizing for the commit trace path.
// trace_rec_t is the record the host sees: sequence stamp followed by the checker bundle.
package ccheck_pkg;

  localparam int DATA_W    = 32;
  localparam int SEQ_W     = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] rd;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO: memory array plus a registered head,
// so the read side never sees a combinational path from the write side.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_valid;
  logic [W-1:0]  r_head;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rptr_nxt;
  logic [LW-1:0] w_level_nxt;
  logic [W-1:0]  w_head_nxt;

  // Flush wins over both sides; a push into a full FIFO needs a same-cycle pop.
  assign w_pop  = i_pop && r_valid && !i_flush;
  assign w_push = i_push && !i_flush && (!r_full || w_pop);

  always_comb begin
    w_rptr_nxt  = r_rptr + AW'(w_pop);
    w_level_nxt = r_level;
    w_head_nxt  = r_head;
    if (i_flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_level_nxt = r_level + 1'b1;
        2'b01:   w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
    end
    // The entry being written this edge becomes the head only when it lands at the new read pointer.
    if (w_level_nxt != '0) begin
      if (w_push && (w_rptr_nxt == r_wptr)) begin
        w_head_nxt = i_wdata;
      end else begin
        w_head_nxt = r_mem[w_rptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      r_wptr  <= i_flush ? '0 : (r_wptr + AW'(w_push));
      r_rptr  <= i_flush ? '0 : w_rptr_nxt;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
      r_valid <= (w_level_nxt != '0);
      r_head  <= w_head_nxt;
    end
  end

  assign o_rdata = r_head;
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = !r_valid;

endmodule

// File: rtl/commit_trace_buffer.sv
// Stamps each committed instruction with a sequence number and buffers it for the host.
// Output handshake: a record transfers on any edge where out_valid && out_ready; out_valid is registered.
module commit_trace_buffer
  import ccheck_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   commit_valid,
  input  logic [DATA_W-1:0]      pc,
  input  logic [DATA_W-1:0]      rs_value,
  input  logic [DATA_W-1:0]      rt_value,
  input  logic [DATA_W-1:0]      rd_value,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output trace_rec_t             out_rec,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic [CNT_W-1:0]       overflow_cnt
);

  logic [SEQ_W-1:0] r_seq;
  logic [CNT_W-1:0] r_ovf;

  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  trace_rec_t w_rec;
  trace_rec_t w_head;

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_push    = commit_valid && !flush && (!full || w_pop);
  assign w_drop    = commit_valid && !flush && full && !w_pop;

  always_comb begin
    w_rec    = '0;
    w_rec.seq = r_seq;
    w_rec.pc  = pc;
    w_rec.rs  = rs_value;
    w_rec.rt  = rt_value;
    w_rec.rd  = rd_value;
  end

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (w_rec),
    .o_rdata (w_head),
    .o_level (level),
    .o_full  (full),
    .o_empty (w_empty)
  );

  assign out_rec = w_head;

  // Sequence advances on every presented commit, even dropped or flushed ones, so gaps reveal loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if (commit_valid) begin
      r_seq <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (flush) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != '1)) begin
      r_ovf <= r_ovf + 1'b1;
    end
  end

  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed vector table, corner-case
// sequences and a random phase, all checked against a queue-based reference model.
module tb_commit_trace_buffer;
  import ccheck_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CW    = 160;

  logic                   clk;
  logic                   rst_n;
  logic                   commit_valid;
  logic [DATA_W-1:0]      pc;
  logic [DATA_W-1:0]      rs_value;
  logic [DATA_W-1:0]      rt_value;
  logic [DATA_W-1:0]      rd_value;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  trace_rec_t             out_rec;
  logic [LW-1:0]          level;
  logic                   full;
  logic [CNT_W-1:0]       overflow_cnt;

  commit_trace_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .pc           (pc),
    .rs_value     (rs_value),
    .rt_value     (rt_value),
    .rd_value     (rd_value),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rec      (out_rec),
    .level        (level),
    .full         (full),
    .overflow_cnt (overflow_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [REC_W-1:0]  exp_q[$];
  logic [SEQ_W-1:0]  m_seq;
  logic [CNT_W-1:0]  m_ovf;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", CW'(out_valid), CW'(exp_q.size() > 0));
    chk("level", CW'(level), CW'(exp_q.size()));
    chk("full", CW'(full), CW'(exp_q.size() == DEPTH));
    chk("overflow_cnt", CW'(overflow_cnt), CW'(m_ovf));
    if (exp_q.size() > 0) chk("out_rec", CW'(out_rec), CW'(exp_q[0]));
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input logic cv, input logic rdy, input logic fl,
                      input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    logic       m_full;
    logic       m_pop;
    trace_rec_t r;
    commit_valid = cv;
    out_ready    = rdy;
    flush        = fl;
    pc           = p;
    rs_value     = a;
    rt_value     = b;
    rd_value     = c;
    m_full = (exp_q.size() == DEPTH);
    m_pop  = (exp_q.size() > 0) && rdy && !fl;
    r = '{seq: m_seq, pc: p, rs: a, rt: b, rd: c};
    if (fl) begin
      exp_q.delete();
      m_ovf = '0;
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (cv) begin
        if (!m_full || m_pop) exp_q.push_back(r);
        else if (m_ovf != '1) m_ovf = m_ovf + 1'b1;
      end
    end
    if (cv) m_seq = m_seq + 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic commit(input logic [DATA_W-1:0] p, input logic rdy);
    step(1'b1, rdy, 1'b0, p, $urandom, $urandom, $urandom);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, rdy, 1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    commit_valid = 1'b0;
    out_ready    = 1'b0;
    flush        = 1'b0;
    pc           = '0;
    rs_value     = '0;
    rt_value     = '0;
    rd_value     = '0;
    exp_q.delete();
    m_seq = '0;
    m_ovf = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", CW'(out_valid), CW'(1'b0));
    chk("rst_level", CW'(level), CW'(0));
    chk("rst_full", CW'(full), CW'(1'b0));
    chk("rst_overflow", CW'(overflow_cnt), CW'(0));
    chk("rst_out_rec", CW'(out_rec), CW'(0));
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic              cv;
    logic              rdy;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] rd;
    logic              exp_valid;
    logic [LW-1:0]     exp_level;
    logic [SEQ_W-1:0]  exp_seq;
  } vec_t;

  vec_t             vecs[7];
  logic [SEQ_W-1:0] exp5[3];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0040_0000, 32'd1, 32'd2, 32'd3, 1'b1, 5'd1, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 32'h0040_0004, 32'd4, 32'd5, 32'd6, 1'b1, 5'd1, 16'd1};
    vecs[3] = '{1'b1, 1'b0, 32'h0040_0008, 32'd7, 32'd8, 32'd9, 1'b1, 5'd2, 16'd1};
    vecs[4] = '{1'b1, 1'b1, 32'h0040_000c, 32'd10, 32'd11, 32'd12, 1'b1, 5'd2, 16'd2};
    vecs[5] = '{1'b0, 1'b1, 32'h0,         32'd0, 32'd0, 32'd0, 1'b1, 5'd1, 16'd3};
    vecs[6] = '{1'b0, 1'b1, 32'h0,         32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 16'd0};
    exp5 = '{16'hfffe, 16'hffff, 16'h0000};

    // Single commit and short push/pop patterns from reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].cv, vecs[i].rdy, 1'b0, vecs[i].pc, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      chk("vec_valid", CW'(out_valid), CW'(vecs[i].exp_valid));
      chk("vec_level", CW'(level), CW'(vecs[i].exp_level));
      if (vecs[i].exp_valid) chk("vec_seq", CW'(out_rec.seq), CW'(vecs[i].exp_seq));
      if (i == 0) begin
        chk("t1_pc", CW'(out_rec.pc), CW'(32'h0040_0000));
        chk("t1_rd", CW'(out_rec.rd), CW'(32'd3));
      end
    end

    // Fill, overflow, drain, and the seq gap after drops
    do_reset();
    for (int i = 0; i < 16; i++) commit(32'h1000 + 32'(i * 4), 1'b0);
    chk("t2_full", CW'(full), CW'(1'b1));
    chk("t2_level", CW'(level), CW'(16));
    commit(32'h2000, 1'b0);
    commit(32'h2004, 1'b0);
    chk("t2_overflow", CW'(overflow_cnt), CW'(2));
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_seq", CW'(out_rec.seq), CW'(i));
      idle(1'b1);
    end
    chk("t2_empty", CW'(out_valid), CW'(1'b0));
    commit(32'h3000, 1'b0);
    chk("t2_gap_seq", CW'(out_rec.seq), CW'(18));

    // Full with simultaneous push and pop
    for (int i = 0; i < 15; i++) commit(32'h4000 + 32'(i * 4), 1'b0);
    chk("t3_full", CW'(full), CW'(1'b1));
    commit(32'h5000, 1'b1);
    chk("t3_level", CW'(level), CW'(16));
    chk("t3_overflow", CW'(overflow_cnt), CW'(2));
    chk("t3_head_seq", CW'(out_rec.seq), CW'(19));

    // Flush with a same-cycle commit
    for (int i = 0; i < 11; i++) idle(1'b1);
    chk("t4_level5", CW'(level), CW'(5));
    step(1'b1, 1'b1, 1'b1, 32'h6000, 32'd0, 32'd0, 32'd0);
    chk("t4_valid", CW'(out_valid), CW'(1'b0));
    chk("t4_level", CW'(level), CW'(0));
    chk("t4_overflow", CW'(overflow_cnt), CW'(0));
    commit(32'h6004, 1'b0);
    chk("t4_seq", CW'(out_rec.seq), CW'(36));

    // Sequence wrap: advance seq_ctr to 0xFFFE using flushed commits
    do_reset();
    for (int i = 0; i < 65534; i++) step(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) commit(32'h7000 + 32'(i * 4), 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_wrap_seq", CW'(out_rec.seq), CW'(exp5[i]));
      idle(1'b1);
    end

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 9; i++) commit(32'h8000 + 32'(i * 4), 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t6_level7", CW'(level), CW'(7));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", CW'(out_valid), CW'(1'b0));
    chk("t6_async_level", CW'(level), CW'(0));
    chk("t6_async_full", CW'(full), CW'(1'b0));
    exp_q.delete();
    m_seq = '0;
    m_ovf = '0;
    commit_valid = 1'b0;
    out_ready    = 1'b0;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    commit(32'h9000, 1'b0);
    chk("t6_seq0", CW'(out_rec.seq), CW'(0));

    // Random traffic with backpressure and occasional flushes
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 63) == 0), $urandom, $urandom, $urandom, $urandom);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);
    chk("final_empty", CW'(out_valid), CW'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
